rvfi_commit_monitor: RTL

- Parametrised retirement monitor for the pipelined rv32i core, instantiated in the mp4 top level next to the DUT.
- Takes up to RETIRE_W retirement lanes per cycle and produces registered per-lane commit strobes and per-lane instruction order numbers.
- Detects the halt idiom: a branch/jal whose target equals its own PC, retired HALT_REPEAT times in a row. Halt is latched sticky.
- Raises a sticky timeout when no instruction retires for TIMEOUT cycles.

---
 rtl/rvfi_commit_monitor.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rvfi_commit_monitor.sv
// Retirement monitor: per-lane commit strobes and order numbers, halt-idiom
// detection (self-looping branch/jal) and an idle-retirement timeout.
module rvfi_commit_monitor #(
    parameter int XLEN        = 32,
    parameter int RETIRE_W    = 1,
    parameter int ORDER_W     = 64,
    parameter int HALT_REPEAT = 1,
    parameter int TIMEOUT     = 100000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic [RETIRE_W-1:0]          ret_valid,
    input  logic [RETIRE_W*XLEN-1:0]     ret_pc_rdata,
    input  logic [RETIRE_W*XLEN-1:0]     ret_pc_wdata,
    input  logic [RETIRE_W*7-1:0]        ret_opcode,
    output logic [RETIRE_W-1:0]          commit,
    output logic [RETIRE_W*ORDER_W-1:0]  order,
    output logic                         halt,
    output logic [XLEN-1:0]              halt_pc,
    output logic                         timeout,
    output logic [ORDER_W-1:0]           commit_count
);

    localparam int LOOP_W = (HALT_REPEAT > 0) ? $clog2(HALT_REPEAT + 1) : 1;
    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    logic [ORDER_W-1:0]          order_cnt;
    logic [LOOP_W-1:0]           loop_cnt;
    logic [IDLE_W-1:0]           idle_cnt;

    logic [RETIRE_W-1:0]         loop_lane;
    logic [RETIRE_W-1:0]         accepted;
    logic [RETIRE_W*ORDER_W-1:0] order_nxt;
    logic [ORDER_W-1:0]          n_accepted;
    logic [LOOP_W-1:0]           loop_nxt;
    logic                        halt_hit;
    logic [XLEN-1:0]             halt_pc_nxt;
    logic                        any_valid;
    logic [IDLE_W-1:0]           idle_nxt;
    logic                        timeout_hit;
    int                          scan_c;

    // Lanes are valid-only (no ready): lane i is consumed on every rising
    // edge where ret_valid[i] is high; the monitor never back-pressures.
    always_comb begin
        loop_lane = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            loop_lane[i] = ret_valid[i]
                && (ret_opcode[i*7 +: 7] == OP_BRANCH || ret_opcode[i*7 +: 7] == OP_JAL)
                && (ret_pc_wdata[i*XLEN +: XLEN] == ret_pc_rdata[i*XLEN +: XLEN]);
        end
    end

    // Oldest-first scan; lanes after the halting lane are dropped.
    always_comb begin
        scan_c      = int'(loop_cnt);
        halt_hit    = 1'b0;
        halt_pc_nxt = '0;
        accepted    = '0;
        order_nxt   = '0;
        n_accepted  = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            order_nxt[i*ORDER_W +: ORDER_W] = order_cnt + n_accepted;
            if (ret_valid[i] && !halt_hit && !halt) begin
                accepted[i] = 1'b1;
                n_accepted  = n_accepted + ORDER_W'(1);
                scan_c      = loop_lane[i] ? scan_c + 1 : 0;
                if (scan_c >= HALT_REPEAT) begin
                    halt_hit    = 1'b1;
                    halt_pc_nxt = ret_pc_rdata[i*XLEN +: XLEN];
                end
            end
        end
        loop_nxt = LOOP_W'(scan_c);
    end

    always_comb begin
        any_valid   = |ret_valid;
        idle_nxt    = idle_cnt;
        timeout_hit = 1'b0;
        if (any_valid) begin
            idle_nxt = '0;
        end else if (TIMEOUT != 0 && !timeout) begin
            idle_nxt = idle_cnt + IDLE_W'(1);
            if (idle_nxt == IDLE_W'(TIMEOUT)) timeout_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit    <= '0;
            order     <= '0;
            halt      <= 1'b0;
            halt_pc   <= '0;
            timeout   <= 1'b0;
            order_cnt <= '0;
            loop_cnt  <= '0;
            idle_cnt  <= '0;
        end else if (clear) begin
            commit    <= '0;
            order     <= '0;
            halt      <= 1'b0;
            halt_pc   <= '0;
            timeout   <= 1'b0;
            order_cnt <= '0;
            loop_cnt  <= '0;
            idle_cnt  <= '0;
        end else begin
            commit <= accepted;
            // Once halted every counter and the captured PC freeze.
            if (!halt) begin
                order     <= order_nxt;
                order_cnt <= order_cnt + n_accepted;
                loop_cnt  <= loop_nxt;
                idle_cnt  <= idle_nxt;
                if (halt_hit) begin
                    halt    <= 1'b1;
                    halt_pc <= halt_pc_nxt;
                end
                if (timeout_hit) timeout <= 1'b1;
            end
        end
    end

    assign commit_count = order_cnt;

endmodule
